alu_issue_ctrl: RTL and testbench

Sequential initiator for the combinational ALU. It accepts one MIPS instruction's decoded fields and register operands over a valid/ready handshake, and encodes opcode/funct into the ALU's 4-bit operation select. It drives registered operands to the ALU for one full cycle, then captures result and zero flag and returns them over a second valid/ready handshake. It sits between the decode/register-read stage and the ALU in the multi-cycle datapath.

---
 rtl/alu_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded MIPS instruction to the combinational ALU and returns its result.
// Latency: legal op response valid 2 edges after accept, illegal op 1 edge after accept.
// Backpressure: in_ready only in IDLE; RESP holds outputs until out_ready; optional shifts via ALU_ISSUE_SHIFT_EN.
module alu_issue_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic [4:0]            shamt,
    input  logic [15:0]           imm,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    output logic [DATA_WIDTH-1:0] alu_operand1,
    output logic [DATA_WIDTH-1:0] alu_operand2,
    output logic [SEL_WIDTH-1:0]  alu_opSel,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_zero,
    output logic                  out_illegal
);

    localparam logic [SEL_WIDTH-1:0] SEL_ADD = SEL_WIDTH'(0);
    localparam logic [SEL_WIDTH-1:0] SEL_SUB = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] SEL_AND = SEL_WIDTH'(2);
    localparam logic [SEL_WIDTH-1:0] SEL_OR  = SEL_WIDTH'(3);
    localparam logic [SEL_WIDTH-1:0] SEL_SLT = SEL_WIDTH'(4);
    localparam logic [SEL_WIDTH-1:0] SEL_XOR = SEL_WIDTH'(5);
    localparam logic [SEL_WIDTH-1:0] SEL_NOR = SEL_WIDTH'(6);
`ifdef ALU_ISSUE_SHIFT_EN
    localparam logic [SEL_WIDTH-1:0] SEL_SLL = SEL_WIDTH'(7);
    localparam logic [SEL_WIDTH-1:0] SEL_SRL = SEL_WIDTH'(8);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_op1;
    logic [DATA_WIDTH-1:0] r_op2;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;
    logic                  r_illegal;

    logic                  w_legal;
    logic [SEL_WIDTH-1:0]  w_sel;
    logic [DATA_WIDTH-1:0] w_op1;
    logic [DATA_WIDTH-1:0] w_op2;
    logic [DATA_WIDTH-1:0] w_imm_sx;
    logic [DATA_WIDTH-1:0] w_imm_zx;

    assign w_imm_sx = {{(DATA_WIDTH-16){imm[15]}}, imm};
    assign w_imm_zx = {{(DATA_WIDTH-16){1'b0}}, imm};

    // Decode opcode/funct into ALU select and operand sources; anything unmatched is illegal.
    always_comb begin
        w_legal = 1'b0;
        w_sel   = SEL_ADD;
        w_op1   = rs_data;
        w_op2   = rt_data;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21: begin w_legal = 1'b1; w_sel = SEL_ADD; end
                    6'h22, 6'h23: begin w_legal = 1'b1; w_sel = SEL_SUB; end
                    6'h24:        begin w_legal = 1'b1; w_sel = SEL_AND; end
                    6'h25:        begin w_legal = 1'b1; w_sel = SEL_OR;  end
                    6'h2A:        begin w_legal = 1'b1; w_sel = SEL_SLT; end
                    6'h26:        begin w_legal = 1'b1; w_sel = SEL_XOR; end
                    6'h27:        begin w_legal = 1'b1; w_sel = SEL_NOR; end
`ifdef ALU_ISSUE_SHIFT_EN
                    6'h00: begin
                        w_legal = 1'b1;
                        w_sel   = SEL_SLL;
                        w_op1   = {{(DATA_WIDTH-5){1'b0}}, shamt};
                    end
                    6'h02: begin
                        w_legal = 1'b1;
                        w_sel   = SEL_SRL;
                        w_op1   = {{(DATA_WIDTH-5){1'b0}}, shamt};
                    end
`endif
                    default: w_legal = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin w_legal = 1'b1; w_sel = SEL_ADD; w_op2 = w_imm_sx; end
            6'h0A:        begin w_legal = 1'b1; w_sel = SEL_SLT; w_op2 = w_imm_sx; end
            6'h0C:        begin w_legal = 1'b1; w_sel = SEL_AND; w_op2 = w_imm_zx; end
            6'h0D:        begin w_legal = 1'b1; w_sel = SEL_OR;  w_op2 = w_imm_zx; end
            6'h0E:        begin w_legal = 1'b1; w_sel = SEL_XOR; w_op2 = w_imm_zx; end
            6'h04, 6'h05: begin w_legal = 1'b1; w_sel = SEL_SUB; end
            default:      w_legal = 1'b0;
        endcase
    end

    // Issue FSM: ALU drive registers load on a legal accept only; the response is captured after one EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op1     <= '0;
            r_op2     <= '0;
            r_sel     <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_legal) begin
                            r_op1   <= w_op1;
                            r_op2   <= w_op2;
                            r_sel   <= w_sel;
                            r_state <= S_EXEC;
                        end else begin
                            r_result  <= '0;
                            r_zero    <= 1'b0;
                            r_illegal <= 1'b1;
                            r_state   <= S_RESP;
                        end
                    end
                end
                S_EXEC: begin
                    r_result  <= alu_result;
                    r_zero    <= alu_zero;
                    r_illegal <= 1'b0;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = (r_state == S_IDLE);
    assign out_valid    = (r_state == S_RESP);
    assign alu_operand1 = r_op1;
    assign alu_operand2 = r_op2;
    assign alu_opSel    = r_sel;
    assign out_result   = r_result;
    assign out_zero     = r_zero;
    assign out_illegal  = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed table-driven bench for alu_issue_ctrl with a behavioural ALU attached.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Shift expectations follow ALU_ISSUE_SHIFT_EN.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] alu_operand1;
    logic [31:0] alu_operand2;
    logic [3:0]  alu_opSel;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    // Expected contents of the ALU drive registers, tracked by the bench.
    logic [31:0] t_op1 = '0;
    logic [31:0] t_op2 = '0;
    logic [3:0]  t_sel = '0;

    typedef struct {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic [3:0]  e_sel;
        logic [31:0] e_res;
        logic        e_zero;
        logic        e_ill;
    } vec_t;

    vec_t vecs[$];

    alu_issue_ctrl #(.DATA_WIDTH(32), .SEL_WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .funct        (funct),
        .shamt        (shamt),
        .imm          (imm),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_opSel    (alu_opSel),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_illegal  (out_illegal)
    );

    always #5 clk = ~clk;

    // Behavioural ALU (unsigned compare, shifts by operand1[4:0]).
    always_comb begin
        alu_result = '0;
        case (alu_opSel)
            4'd0: alu_result = alu_operand1 + alu_operand2;
            4'd1: alu_result = alu_operand1 - alu_operand2;
            4'd2: alu_result = alu_operand1 & alu_operand2;
            4'd3: alu_result = alu_operand1 | alu_operand2;
            4'd4: alu_result = {31'd0, alu_operand1 < alu_operand2};
            4'd5: alu_result = alu_operand1 ^ alu_operand2;
            4'd6: alu_result = ~(alu_operand1 | alu_operand2);
            4'd7: alu_result = alu_operand2 << alu_operand1[4:0];
            4'd8: alu_result = alu_operand2 >> alu_operand1[4:0];
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] e1, input logic [31:0] e2, input logic [3:0] es,
                                input logic [31:0] er, input logic ez, input logic ei);
        vec_t v;
        v.opcode = op; v.funct = fn; v.shamt = sh; v.imm = im; v.rs = rs; v.rt = rt;
        v.e_op1 = e1; v.e_op2 = e2; v.e_sel = es; v.e_res = er; v.e_zero = ez; v.e_ill = ei;
        return v;
    endfunction

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt);
        opcode = op; funct = fn; shamt = sh; imm = im; rs_data = rs; rt_data = rt;
    endtask

    // Called just after a falling edge with the DUT idle; returns just after a falling edge, idle again.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        drive(v.opcode, v.funct, v.shamt, v.imm, v.rs, v.rt);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        // Scramble fields after the accept edge; they must not matter any more.
        in_valid = 1'b0;
        drive(6'h3F, 6'h3F, 5'h1F, ~v.imm, ~v.rs, ~v.rt);
        chk({tag, ".in_ready_busy"}, {31'd0, in_ready}, 32'd0);
        if (!v.e_ill) begin
            t_op1 = v.e_op1; t_op2 = v.e_op2; t_sel = v.e_sel;
            chk({tag, ".valid_exec"}, {31'd0, out_valid}, 32'd0);
            chk({tag, ".op1"}, alu_operand1, t_op1);
            chk({tag, ".op2"}, alu_operand2, t_op2);
            chk({tag, ".sel"}, {28'd0, alu_opSel}, {28'd0, t_sel});
            @(negedge clk);
        end
        chk({tag, ".valid_resp"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".result"}, out_result, v.e_res);
        chk({tag, ".zero"}, {31'd0, out_zero}, {31'd0, v.e_zero});
        chk({tag, ".illegal"}, {31'd0, out_illegal}, {31'd0, v.e_ill});
        chk({tag, ".op1_hold"}, alu_operand1, t_op1);
        chk({tag, ".op2_hold"}, alu_operand2, t_op2);
        chk({tag, ".sel_hold"}, {28'd0, alu_opSel}, {28'd0, t_sel});
        @(negedge clk);
        chk({tag, ".valid_done"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".in_ready_done"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".op1"}, alu_operand1, 32'd0);
        chk({tag, ".op2"}, alu_operand2, 32'd0);
        chk({tag, ".sel"}, {28'd0, alu_opSel}, 32'd0);
        chk({tag, ".result"}, out_result, 32'd0);
        chk({tag, ".zero"}, {31'd0, out_zero}, 32'd0);
        chk({tag, ".illegal"}, {31'd0, out_illegal}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(6'd0, 6'd0, 5'd0, 16'd0, 32'd0, 32'd0);

        //          op     fn     sh     imm       rs            rt            e_op1         e_op2         sel   result        z     ill
        vecs.push_back(mk(6'h00, 6'h20, 5'd0, 16'h0000, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0005, 32'hFFFF_FFFB, 4'd0, 32'h0000_0000, 1'b1, 1'b0));
        vecs.push_back(mk(6'h00, 6'h21, 5'd0, 16'h0000, 32'h0000_0003, 32'h0000_0004, 32'h0000_0003, 32'h0000_0004, 4'd0, 32'h0000_0007, 1'b0, 1'b0));
        vecs.push_back(mk(6'h00, 6'h22, 5'd0, 16'h0000, 32'h0000_000A, 32'h0000_0003, 32'h0000_000A, 32'h0000_0003, 4'd1, 32'h0000_0007, 1'b0, 1'b0));
        vecs.push_back(mk(6'h00, 6'h23, 5'd0, 16'h0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 4'd1, 32'hFFFF_FFFF, 1'b0, 1'b0));
        vecs.push_back(mk(6'h00, 6'h24, 5'd0, 16'h0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F0F0, 32'h0000_FF00, 4'd2, 32'h0000_F000, 1'b0, 1'b0));
        vecs.push_back(mk(6'h00, 6'h25, 5'd0, 16'h0000, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00F0, 32'h0000_000F, 4'd3, 32'h0000_00FF, 1'b0, 1'b0));
        vecs.push_back(mk(6'h00, 6'h2A, 5'd0, 16'h0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 4'd4, 32'h0000_0001, 1'b0, 1'b0));
        vecs.push_back(mk(6'h00, 6'h26, 5'd0, 16'h0000, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00FF, 32'h0000_000F, 4'd5, 32'h0000_00F0, 1'b0, 1'b0));
        vecs.push_back(mk(6'h00, 6'h27, 5'd0, 16'h0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'd6, 32'hFFFF_FFFF, 1'b0, 1'b0));
        vecs.push_back(mk(6'h08, 6'h00, 5'd0, 16'hFFFF, 32'h0000_0001, 32'h1234_5678, 32'h0000_0001, 32'hFFFF_FFFF, 4'd0, 32'h0000_0000, 1'b1, 1'b0));
        vecs.push_back(mk(6'h0D, 6'h00, 5'd0, 16'h8000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_8000, 4'd3, 32'h0000_8000, 1'b0, 1'b0));
        // Illegal opcode right after ORI: drive registers must still hold the ORI values.
        vecs.push_back(mk(6'h3F, 6'h20, 5'd0, 16'h0000, 32'h1111_1111, 32'h2222_2222, 32'h0,          32'h0,          4'd0, 32'h0000_0000, 1'b0, 1'b1));
        vecs.push_back(mk(6'h0A, 6'h00, 5'd0, 16'h0005, 32'h0000_0003, 32'h0000_0000, 32'h0000_0003, 32'h0000_0005, 4'd4, 32'h0000_0001, 1'b0, 1'b0));
        vecs.push_back(mk(6'h0C, 6'h00, 5'd0, 16'hFFFF, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h0000_FFFF, 4'd2, 32'h0000_5678, 1'b0, 1'b0));
        vecs.push_back(mk(6'h0E, 6'h00, 5'd0, 16'h00FF, 32'h0000_00FF, 32'h0000_0000, 32'h0000_00FF, 32'h0000_00FF, 4'd5, 32'h0000_0000, 1'b1, 1'b0));
        vecs.push_back(mk(6'h05, 6'h00, 5'd0, 16'h1234, 32'h0000_0009, 32'h0000_0009, 32'h0000_0009, 32'h0000_0009, 4'd1, 32'h0000_0000, 1'b1, 1'b0));
        vecs.push_back(mk(6'h00, 6'h3F, 5'd0, 16'h0000, 32'h0000_0001, 32'h0000_0001, 32'h0,          32'h0,          4'd0, 32'h0000_0000, 1'b0, 1'b1));
`ifdef ALU_ISSUE_SHIFT_EN
        vecs.push_back(mk(6'h00, 6'h00, 5'd4, 16'h0000, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0004, 32'h0000_0001, 4'd7, 32'h0000_0010, 1'b0, 1'b0));
        vecs.push_back(mk(6'h00, 6'h02, 5'd8, 16'h0000, 32'hDEAD_BEEF, 32'h0000_1200, 32'h0000_0008, 32'h0000_1200, 4'd8, 32'h0000_0012, 1'b0, 1'b0));
`else
        vecs.push_back(mk(6'h00, 6'h00, 5'd4, 16'h0000, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0,          32'h0,          4'd0, 32'h0000_0000, 1'b0, 1'b1));
        vecs.push_back(mk(6'h00, 6'h02, 5'd8, 16'h0000, 32'hDEAD_BEEF, 32'h0000_1200, 32'h0,          32'h0,          4'd0, 32'h0000_0000, 1'b0, 1'b1));
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-pressure: BEQ rs=rt=7 stalled 5 cycles while a new request waits.
        drive(6'h04, 6'h00, 5'd0, 16'h0000, 32'd7, 32'd7);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        drive(6'h00, 6'h20, 5'd0, 16'h0000, 32'd2, 32'd3);
        chk("bp.in_ready_exec", {31'd0, in_ready}, 32'd0);
        chk("bp.sel", {28'd0, alu_opSel}, 32'd1);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp.valid%0d", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp.zero%0d", k), {31'd0, out_zero}, 32'd1);
            chk($sformatf("bp.result%0d", k), out_result, 32'd0);
            chk($sformatf("bp.in_ready%0d", k), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp.op1_%0d", k), alu_operand1, 32'd7);
            @(negedge clk);
        end
        chk("bp.still_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.released", {31'd0, out_valid}, 32'd0);
        chk("bp.not_loaded", alu_operand1, 32'd7);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.next_op1", alu_operand1, 32'd2);
        chk("bp.next_op2", alu_operand2, 32'd3);
        @(negedge clk);
        chk("bp.next_valid", {31'd0, out_valid}, 32'd1);
        chk("bp.next_result", out_result, 32'd5);
        @(negedge clk);
        chk("bp.next_done", {31'd0, in_ready}, 32'd1);

        // Reset mid-RESP aborts the response.
        drive(6'h00, 6'h20, 5'd0, 16'h0000, 32'd1, 32'd1);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rr.valid_before", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rr");
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rr.no_valid", {31'd0, out_valid}, 32'd0);
        end

        // Reset mid-EXEC: no response may follow.
        drive(6'h00, 6'h22, 5'd0, 16'h0000, 32'd9, 32'd4);
        in_valid = 1'b1;
        @(posedge clk);
        #2 in_valid = 1'b0;
        rst_n = 1'b0;
        #1 chk_reset_vals("re");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("re.no_valid", {31'd0, out_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
